seq_alu_sequencer: RTL and testbench

SEQ_ALU_SEQUENCER -- requirements
Module: seq_alu_sequencer

---
 rtl/seq_alu_sequencer_if.sv | 28 ++
 rtl/seq_alu_sequencer.sv | 99 +++++++++
 tb/tb_seq_alu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seq_alu_sequencer_if.sv
// rtl/seq_alu_sequencer_if.sv - request/status bundle between the ALU sequencer and its controller.
// The master drives the start request and opcode. The slave (the sequencer) returns the strobes and status.
interface seq_alu_sequencer_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH);

  logic          en;
  logic [1:0]    opcode;
  logic          abort;
  logic [1:0]    op_q;
  logic [2:0]    state;
  logic          load;
  logic          exec;
  logic [CW-1:0] step;
  logic          busy;
  logic          done;

  modport master (
    output en, opcode, abort,
    input  op_q, state, load, exec, step, busy, done
  );

  modport slave (
    input  en, opcode, abort,
    output op_q, state, load, exec, step, busy, done
  );
endinterface

// File: rtl/seq_alu_sequencer.sv
// rtl/seq_alu_sequencer.sv - control FSM sequencing single-step (add/compare) and iterative (mul/div) ALU ops.
// Every output is a flop or a decode of registered state, so no input reaches an output combinationally.
module seq_alu_sequencer #(
  parameter int WIDTH     = 16,
  parameter int GRAY_STEP = 1
) (
  input  logic              clk,
  input  logic              nrst,
  seq_alu_sequencer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD   = 3'b001,
    SINGLE = 3'b011,
    ITER   = 3'b010,
    DONE   = 3'b110
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    op_r;
  logic [1:0]    op_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur  <= IDLE;
      cnt  <= '0;
      op_r <= '0;
    end else begin
      cur  <= nxt;
      cnt  <= cnt_nxt;
      op_r <= op_nxt;
    end
  end

  // The counter defaults to zero, so it is cleared in every state except a continuing ITER.
  always_comb begin
    nxt     = cur;
    cnt_nxt = '0;
    op_nxt  = op_r;
    case (cur)
      IDLE: begin
        if (bus.en && !bus.abort) begin
          nxt    = LOAD;
          op_nxt = bus.opcode;
        end
      end
      LOAD: begin
        if (bus.abort)
          nxt = IDLE;
        else if (op_r == 2'd1 || op_r == 2'd2)
          nxt = ITER;
        else
          nxt = SINGLE;
      end
      SINGLE: begin
        nxt = bus.abort ? IDLE : DONE;
      end
      ITER: begin
        if (bus.abort)
          nxt = IDLE;
        else if (cnt == LAST)
          nxt = DONE;
        else
          cnt_nxt = cnt + ONE;
      end
      DONE: begin
        if (bus.abort) begin
          nxt = IDLE;
        end else if (bus.en) begin
          nxt    = LOAD;
          op_nxt = bus.opcode;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.state = cur;
  assign bus.op_q  = op_r;
  assign bus.load  = (cur == LOAD);
  assign bus.exec  = (cur == SINGLE) || (cur == ITER);
  assign bus.busy  = (cur == LOAD) || (cur == SINGLE) || (cur == ITER);
  assign bus.done  = (cur == DONE);

  generate
    if (GRAY_STEP != 0) begin : g_gray
      assign bus.step = cnt ^ (cnt >> 1);
    end else begin : g_bin
      assign bus.step = cnt;
    end
  endgenerate
endmodule

// File: tb/tb_seq_alu_sequencer.sv
// tb/tb_seq_alu_sequencer.sv - randomized and directed bench for seq_alu_sequencer.
// The reference model tracks the number of cycles since an operation was accepted.
module tb_seq_alu_sequencer;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(WIDTH);

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  seq_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  seq_alu_sequencer #(.WIDTH(WIDTH), .GRAY_STEP(1)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_act;
  int         m_k;
  logic [1:0] m_op;
  bit         prev_iter;
  logic [CW-1:0] prev_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int last_k(input logic [1:0] op);
    return (op == 2'd1 || op == 2'd2) ? WIDTH + 2 : 3;
  endfunction

  task automatic model_reset();
    m_act     = 1'b0;
    m_k       = 0;
    m_op      = 2'd0;
    prev_iter = 1'b0;
  endtask

  task automatic model_edge(input bit e, input logic [1:0] o, input bit a);
    if (!m_act) begin
      if (e && !a) begin m_act = 1'b1; m_k = 1; m_op = o; end
    end else if (a) begin
      m_act = 1'b0; m_k = 0;
    end else if (m_k >= last_k(m_op)) begin
      if (e) begin m_k = 1; m_op = o; end
    end else begin
      m_k++;
    end
  endtask

  task automatic compare_all();
    logic [2:0]    es;
    logic          el, ex, eb, ed;
    logic [CW-1:0] est;
    bit            iter;
    int            idx;
    es = 3'b000; el = 0; ex = 0; eb = 0; ed = 0; est = '0;
    iter = (m_op == 2'd1 || m_op == 2'd2);
    if (m_act) begin
      if (m_k == 1) begin
        es = 3'b001; el = 1; eb = 1;
      end else if (m_k >= last_k(m_op)) begin
        es = 3'b110; ed = 1;
      end else begin
        ex = 1; eb = 1;
        es = iter ? 3'b010 : 3'b011;
        if (iter) begin
          idx = m_k - 2;
          est = CW'(idx ^ (idx >> 1));
        end
      end
    end
    check("state", 32'(bus.state), 32'(es));
    check("op_q",  32'(bus.op_q),  32'(m_op));
    check("load",  32'(bus.load),  32'(el));
    check("exec",  32'(bus.exec),  32'(ex));
    check("step",  32'(bus.step),  32'(est));
    check("busy",  32'(bus.busy),  32'(eb));
    check("done",  32'(bus.done),  32'(ed));
    if (prev_iter && es == 3'b010)
      check("gray_1bit", 32'($countones(prev_step ^ bus.step)), 32'd1);
    prev_iter = (es == 3'b010);
    prev_step = bus.step;
  endtask

  task automatic tick(input bit e, input logic [1:0] o, input bit a);
    bus.en = e; bus.opcode = o; bus.abort = a;
    @(posedge clk);
    model_edge(e, o, a);
    #1;
    compare_all();
  endtask

  initial begin
    nrst = 1'b0;
    bus.en = 1'b1; bus.opcode = 2'd0; bus.abort = 1'b0;
    model_reset();
    #2;
    compare_all();
    #10;
    check("reset_held_after_edge", 32'(bus.state), 32'd0);
    compare_all();
    nrst = 1'b1;
    // en is already high at release; first accept happens on the next edge only.
    tick(1, 2'd0, 0);
    tick(0, 2'd0, 0);
    tick(0, 2'd0, 0);
    repeat (3) tick(0, 2'd1, 0);
    tick(0, 2'd0, 1);
    tick(0, 2'd0, 1);
    tick(1, 2'd1, 0);
    repeat (19) tick(0, 2'd0, 0);
    tick(1, 2'd2, 0);
    repeat (17) tick(1, 2'($urandom), 0);
    repeat (2) tick(0, 2'd0, 0);
    tick(0, 2'd0, 1);
    tick(1, 2'd1, 0);
    repeat (6) tick(0, 2'd0, 0);
    check("abort_point_step", 32'(bus.step), 32'(5 ^ (5 >> 1)));
    tick(1, 2'd3, 1);
    repeat (20) tick(0, 2'd0, 0);
    tick(1, 2'd2, 0);
    repeat (5) tick(0, 2'd0, 0);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    nrst = 1'b1;
    tick(1, 2'd3, 0);
    tick(0, 2'd0, 0);
    tick(0, 2'd0, 0);
    check("cmp_latency_done", 32'(bus.done), 32'd1);
    tick(0, 2'd0, 0);
    repeat (1500) begin
      tick(($urandom_range(0, 3) == 0), 2'($urandom), ($urandom_range(0, 39) == 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
